// File: rtl/mem_types_pkg.sv
// Shared memory-message types: op encoding and the request/response message
// layout used by mem_responder and the processor-side memory interface.
package mem_types_pkg;

  // Widest opaque tag a message can carry; narrower tags are zero-extended
  // into this field and truncated back out on the response side.
  localparam int MEM_OPAQ_MAX = 32;
  localparam int MEM_ADDR_W   = 32;
  localparam int MEM_DATA_W   = 32;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_e;

  // One message format serves both directions: for requests data is the
  // write data, for responses it is the read data (0 for writes).
  typedef struct packed {
    mem_op_e                 op;
    logic [MEM_OPAQ_MAX-1:0] opaque;
    logic [MEM_ADDR_W-1:0]   addr;
    logic [MEM_DATA_W-1:0]   data;
  } mem_msg_t;

  localparam int MEM_MSG_W = $bits(mem_msg_t);

endpackage

// File: rtl/mem_resp_fifo.sv
// Two-entry in-order response buffer. Push is ignored when full and pop is
// ignored when empty; push and pop on the same edge keep occupancy unchanged.
// The head entry is driven as zero while empty so idle outputs read as 0.
module mem_resp_fifo #(
  parameter int p_width = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [p_width-1:0] push_data,
  input  logic               pop,
  output logic [p_width-1:0] pop_data,
  output logic               full,
  output logic               empty
);

  logic [p_width-1:0] entries [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = empty ? '0 : entries[rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_responder.sv
// Single-port test memory with a val/rdy request port and a val/rdy response
// port. Requests are serviced on acceptance and their responses queue in a
// two-entry buffer; interval counters throttle acceptance and response rates.
//
// Handshake: a transfer happens on a rising edge where val and rdy are both
// high. req_rdy and resp_val come only from registered state (and rst), never
// from req_val or resp_rdy; a presented response holds its payload until taken.
module mem_responder
  import mem_types_pkg::*;
#(
  parameter int p_opaq_bits       = 8,
  parameter int p_num_words       = 256,
  parameter int p_recv_intv_delay = 1,
  parameter int p_send_intv_delay = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [p_opaq_bits-1:0] req_opaque,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_data,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_op,
  output logic [p_opaq_bits-1:0] resp_opaque,
  output logic [31:0]            resp_addr,
  output logic [31:0]            resp_data,
  input  logic                   init_en,
  input  logic [31:0]            init_addr,
  input  logic [31:0]            init_data
);

  localparam int IDX_W = $clog2(p_num_words);
  localparam int RCW   = (p_recv_intv_delay > 1) ? $clog2(p_recv_intv_delay) : 1;
  localparam int SCW   = (p_send_intv_delay > 1) ? $clog2(p_send_intv_delay) : 1;

  logic [31:0]      mem [p_num_words];
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] init_idx;
  logic [RCW-1:0]   recv_cnt;
  logic [SCW-1:0]   send_cnt;
  logic             accept;
  logic             resp_fire;
  logic             fifo_full;
  logic             fifo_empty;
  mem_msg_t         push_msg;
  mem_msg_t         resp_msg;
  logic [MEM_MSG_W-1:0] fifo_out;
  logic             unused_bits;

  // Word index drops the byte offset; upper bits alias, so addresses wrap.
  assign req_idx  = req_addr[IDX_W+1:2];
  assign init_idx = init_addr[IDX_W+1:2];

  assign req_rdy   = ~rst & (recv_cnt == '0) & ~fifo_full;
  assign resp_val  = ~rst & (send_cnt == '0) & ~fifo_empty;
  assign accept    = req_val & req_rdy;
  assign resp_fire = resp_val & resp_rdy;

  // Build the response for the request being accepted this edge; a read sees
  // the array before this edge's writes land.
  always_comb begin
    push_msg        = '0;
    push_msg.op     = mem_op_e'(req_op);
    push_msg.opaque = MEM_OPAQ_MAX'(req_opaque);
    push_msg.addr   = req_addr;
    push_msg.data   = (mem_op_e'(req_op) == MEM_WRITE) ? 32'd0 : mem[req_idx];
  end

  // Memory array, not reset. The request write is issued after the backdoor
  // write so that it wins when both hit the same word on one edge.
  always_ff @(posedge clk) begin
    if (init_en) mem[init_idx] <= init_data;
    if (accept && (mem_op_e'(req_op) == MEM_WRITE)) mem[req_idx] <= req_data;
  end

  // Acceptance interval: reload on each accepted request, count down to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      recv_cnt <= '0;
    end else if (accept) begin
      recv_cnt <= RCW'(p_recv_intv_delay - 1);
    end else if (recv_cnt != '0) begin
      recv_cnt <= recv_cnt - RCW'(1);
    end
  end

  // Response interval: reload on each response transfer, count down to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_cnt <= '0;
    end else if (resp_fire) begin
      send_cnt <= SCW'(p_send_intv_delay - 1);
    end else if (send_cnt != '0) begin
      send_cnt <= send_cnt - SCW'(1);
    end
  end

  mem_resp_fifo #(
    .p_width (MEM_MSG_W)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_msg),
    .pop       (resp_fire),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign resp_msg    = mem_msg_t'(fifo_out);
  assign resp_op     = resp_msg.op;
  assign resp_opaque = resp_msg.opaque[p_opaq_bits-1:0];
  assign resp_addr   = resp_msg.addr;
  assign resp_data   = resp_msg.data;

  // Address bits outside the word index and tag bits above p_opaq_bits.
  assign unused_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0],
                         init_addr[31:IDX_W+2], init_addr[1:0],
                         resp_msg.opaque >> p_opaq_bits};

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: randomized and directed traffic against a
// word-array reference model, with a response scoreboard, plus two extra
// instances exercising the accept and send interval settings.
module tb_mem_responder;

  localparam int OB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main instance (both intervals 1) ----------------
  logic          req_val = 1'b0;
  logic          req_rdy;
  logic          req_op = 1'b0;
  logic [OB-1:0] req_opaque = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_data = '0;
  logic          resp_val;
  logic          resp_rdy = 1'b1;
  logic          resp_op;
  logic [OB-1:0] resp_opaque;
  logic [31:0]   resp_addr;
  logic [31:0]   resp_data;
  logic          init_en = 1'b0;
  logic [31:0]   init_addr = '0;
  logic [31:0]   init_data = '0;

  mem_responder #(
    .p_opaq_bits(OB), .p_num_words(256),
    .p_recv_intv_delay(1), .p_send_intv_delay(1)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op),
    .req_opaque(req_opaque), .req_addr(req_addr), .req_data(req_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_op(resp_op),
    .resp_opaque(resp_opaque), .resp_addr(resp_addr), .resp_data(resp_data),
    .init_en(init_en), .init_addr(init_addr), .init_data(init_data)
  );

  // ---------------- accept interval 3 instance ----------------
  logic          r3_req_val = 1'b0;
  logic          r3_req_rdy, r3_resp_val, r3_resp_op;
  logic [OB-1:0] r3_resp_opaque;
  logic [31:0]   r3_resp_addr, r3_resp_data;

  mem_responder #(
    .p_opaq_bits(OB), .p_num_words(256),
    .p_recv_intv_delay(3), .p_send_intv_delay(1)
  ) u_r3 (
    .clk(clk), .rst(rst),
    .req_val(r3_req_val), .req_rdy(r3_req_rdy), .req_op(1'b0),
    .req_opaque(8'h11), .req_addr(32'h40), .req_data(32'h0),
    .resp_val(r3_resp_val), .resp_rdy(1'b1), .resp_op(r3_resp_op),
    .resp_opaque(r3_resp_opaque), .resp_addr(r3_resp_addr), .resp_data(r3_resp_data),
    .init_en(1'b0), .init_addr(32'h0), .init_data(32'h0)
  );

  // ---------------- send interval 3 instance ----------------
  logic          s3_req_val = 1'b0;
  logic          s3_req_rdy, s3_resp_val, s3_resp_op;
  logic [OB-1:0] s3_resp_opaque;
  logic [31:0]   s3_resp_addr, s3_resp_data;

  mem_responder #(
    .p_opaq_bits(OB), .p_num_words(256),
    .p_recv_intv_delay(1), .p_send_intv_delay(3)
  ) u_s3 (
    .clk(clk), .rst(rst),
    .req_val(s3_req_val), .req_rdy(s3_req_rdy), .req_op(1'b0),
    .req_opaque(8'h22), .req_addr(32'h80), .req_data(32'h0),
    .resp_val(s3_resp_val), .resp_rdy(1'b1), .resp_op(s3_resp_op),
    .resp_opaque(s3_resp_opaque), .resp_addr(s3_resp_addr), .resp_data(s3_resp_data),
    .init_en(1'b0), .init_addr(32'h0), .init_data(32'h0)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepted = 0;
  int rdy_mode = 0;       // 0 always ready, 1 random, 2 held low
  logic [31:0] model_mem [256];
  logic [72:0] exp_q [$]; // {op, tag, addr, data}
  int acc_log [$];
  int pop_log [$];
  int r3_acc [$];
  int s3_acc [$];
  int s3_pop [$];
  bit fork_done;

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_msg(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got op=%0b tag=%h addr=%h data=%h expected op=%0b tag=%h addr=%h data=%h",
               name, act[72], act[71:64], act[63:32], act[31:0],
               exp[72], exp[71:64], exp[63:32], exp[31:0]);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 256);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response-ready driver.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       resp_rdy = 1'b1;
      1:       resp_rdy = ($urandom_range(0, 3) != 0);
      default: resp_rdy = 1'b0;
    endcase
  end

  // Main monitor: pops the scoreboard on each response transfer and checks
  // that a stalled response keeps its payload.
  initial begin : monitor
    logic        hold_v;
    logic [72:0] hold_p;
    logic [72:0] cur;
    hold_v = 1'b0;
    hold_p = '0;
    forever begin
      @(negedge clk);
      cur = {resp_op, resp_opaque, resp_addr, resp_data};
      if (resp_val) begin
        if (hold_v) chk_msg("payload_stable", cur, hold_p);
        if (resp_rdy) begin
          pop_log.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got tag=%h data=%h expected no response",
                     resp_opaque, resp_data);
          end else begin
            chk_msg("resp", cur, exp_q.pop_front());
          end
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          hold_p = cur;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // Interval-instance monitors: log accept and response edges.
  initial forever begin
    @(negedge clk);
    if (r3_req_val && r3_req_rdy) r3_acc.push_back(cyc);
    if (s3_req_val && s3_req_rdy) s3_acc.push_back(cyc);
    if (s3_resp_val) s3_pop.push_back(cyc);
  end

  // Offer one request and hold it until accepted; the model is updated at the
  // acceptance edge: read sees prior contents, backdoor then request write.
  task automatic issue(input logic op, input logic [7:0] tag, input logic [31:0] addr,
                       input logic [31:0] data, input logic ien,
                       input logic [31:0] iaddr, input logic [31:0] idata);
    logic [31:0] rd;
    bit done;
    done = 1'b0;
    req_val = 1'b1; req_op = op; req_opaque = tag; req_addr = addr; req_data = data;
    init_en = ien; init_addr = iaddr; init_data = idata;
    for (int n = 0; n < 60 && !done; n++) begin
      if (req_rdy) begin
        rd = op ? 32'd0 : model_mem[widx(addr)];
        if (ien) model_mem[widx(iaddr)] = idata;
        if (op) model_mem[widx(addr)] = data;
        exp_q.push_back({op, tag, addr, rd});
        acc_log.push_back(cyc);
        accepted++;
        done = 1'b1;
      end
      step();
    end
    req_val = 1'b0;
    init_en = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got no acceptance expected acceptance tag=%h", tag);
    end
  endtask

  task automatic backdoor(input logic [31:0] addr, input logic [31:0] data);
    init_en = 1'b1; init_addr = addr; init_data = data;
    model_mem[widx(addr)] = data;
    step();
    init_en = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) step();
    chk_int(name, exp_q.size(), 0);
  endtask

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic        op, ien;
    logic [7:0]  tag;
    logic [31:0] a, d, ia;

    // Reset state.
    repeat (3) step();
    chk_int("rst_req_rdy", int'(req_rdy), 0);
    chk_int("rst_resp_val", int'(resp_val), 0);
    chk_int("rst_resp_data", int'(resp_data), 0);
    chk_int("rst_resp_opaque", int'(resp_opaque), 0);
    chk_int("rst_resp_op", int'(resp_op), 0);
    rst = 1'b0;
    #1;
    chk_int("req_rdy_after_rst", int'(req_rdy), 1);
    step();

    // Preload the whole array through the backdoor.
    for (int i = 0; i < 256; i++) backdoor(32'(i * 4), $urandom);

    // Write then read the same word on consecutive edges.
    acc_log.delete();
    pop_log.delete();
    issue(1'b1, 8'd3, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 8'd4, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
    drain("drain_wr_rd");
    chk_int("wr_rd_accepts", acc_log.size(), 2);
    if (acc_log.size() == 2) chk_int("wr_rd_accept_gap", acc_log[1] - acc_log[0], 1);
    chk_int("wr_rd_resps", pop_log.size(), 2);
    if (pop_log.size() == 2) chk_int("wr_rd_resp_gap", pop_log[1] - pop_log[0], 1);

    // Response side stalled with three requests offered.
    rdy_mode = 2;
    accepted = 0;
    fork_done = 1'b0;
    fork
      begin
        issue(1'b0, 8'h31, 32'h104, 32'h0, 1'b0, 32'h0, 32'h0);
        issue(1'b1, 8'h32, 32'h108, 32'h5A5A0001, 1'b0, 32'h0, 32'h0);
        issue(1'b0, 8'h33, 32'h108, 32'h0, 1'b0, 32'h0, 32'h0);
        fork_done = 1'b1;
      end
    join_none
    repeat (5) step();
    chk_int("stall_accepted", accepted, 2);
    chk_int("stall_req_rdy", int'(req_rdy), 0);
    rdy_mode = 0;
    for (int n = 0; n < 80 && !fork_done; n++) step();
    chk_int("stall_third_accepted", accepted, 3);
    drain("drain_stall");

    // Address wrap and backdoor/request collision on one word.
    backdoor(32'h0, 32'h12345678);
    issue(1'b0, 8'd5, 32'h400, 32'h0, 1'b0, 32'h0, 32'h0);
    issue(1'b1, 8'd6, 32'h8, 32'hAAAA5555, 1'b1, 32'h808, 32'h11111111);
    issue(1'b0, 8'd7, 32'h8, 32'h0, 1'b0, 32'h0, 32'h0);
    drain("drain_wrap");

    // Randomized traffic over a few words with aliased upper address bits.
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      op  = 1'($urandom_range(0, 1));
      tag = 8'($urandom);
      a   = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      d   = $urandom;
      ien = ($urandom_range(0, 4) == 0);
      ia  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2);
      issue(op, tag, a, d, ien, ia, $urandom);
      if ($urandom_range(0, 3) == 0) step();
    end
    rdy_mode = 0;
    drain("drain_random");

    // Accept interval 3: request held high for four reads.
    r3_req_val = 1'b1;
    for (int n = 0; n < 40 && r3_acc.size() < 4; n++) step();
    r3_req_val = 1'b0;
    chk_int("r3_accepts", r3_acc.size(), 4);
    for (int i = 1; i < r3_acc.size(); i++) chk_int("r3_accept_gap", r3_acc[i] - r3_acc[i-1], 3);

    // Send interval 3: three back-to-back reads, sink always ready.
    s3_req_val = 1'b1;
    for (int n = 0; n < 40 && s3_acc.size() < 3; n++) step();
    s3_req_val = 1'b0;
    chk_int("s3_accepts", s3_acc.size(), 3);
    chk_int("s3_req_rdy_full", int'(s3_req_rdy), 0);
    for (int n = 0; n < 40 && s3_pop.size() < 3; n++) step();
    repeat (4) step();
    chk_int("s3_resps", s3_pop.size(), 3);
    for (int i = 1; i < s3_pop.size(); i++) chk_int("s3_resp_gap", s3_pop[i] - s3_pop[i-1], 3);

    // Reset with two responses buffered; memory must survive.
    rdy_mode = 2;
    step();
    issue(1'b1, 8'h41, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 8'h42, 32'h24, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    chk_int("pre_rst_resp_val", int'(resp_val), 1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk_int("mid_rst_resp_val", int'(resp_val), 0);
    chk_int("mid_rst_req_rdy", int'(req_rdy), 0);
    chk_int("mid_rst_resp_data", int'(resp_data), 0);
    chk_int("mid_rst_resp_addr", int'(resp_addr), 0);
    rdy_mode = 0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk_int("post_rst_req_rdy", int'(req_rdy), 1);
    repeat (3) step();
    chk_int("post_rst_resp_val", int'(resp_val), 0);
    issue(1'b0, 8'h43, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0);
    drain("drain_post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
